cg_enable_ctrl: RTL and testbench

//  Generates the enable for the cgcontrol clock gate (drives its en input directly).

---
 rtl/cg_pkg.sv | 11 +
 rtl/cg_enable_ctrl.sv | 92 +++++++++
 tb/tb_cg_enable_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cg_pkg.sv
// Shared types for the clock-gate enable controller.
package cg_pkg;

  typedef enum logic [1:0] {
    CG_ACTIVE,
    CG_PREP,
    CG_GATED,
    CG_WAKE
  } cg_state_e;

endpackage

// File: rtl/cg_enable_ctrl.sv
// Drives cgcontrol.en: gates the domain clock after a programmable idle period
// and runs a fixed wake sequence before telling upstream it may issue work again.
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic activity,
  input  logic drain_done,
  input  logic force_on,
  output logic cg_en,
  output logic domain_ready,
  output logic gated
);

  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  cg_state_e        r_state;
  cg_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_cg_en;
  logic             r_domain_ready;
  logic             r_gated;
  logic             w_idle;

  assign w_idle = !activity && drain_done && !force_on;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    unique case (r_state)
      CG_ACTIVE: begin
        if (w_idle) begin
          if (r_cnt == IDLE_LAST) begin
            w_state_next = CG_PREP;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      CG_PREP: begin
        w_state_next = w_idle ? CG_GATED : CG_ACTIVE;
      end
      CG_GATED: begin
        // drain_done deliberately plays no part once the clock is stopped
        if (activity || force_on) begin
          w_state_next = CG_WAKE;
        end
      end
      CG_WAKE: begin
        if (r_cnt == WAKE_LAST) begin
          w_state_next = CG_ACTIVE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = CG_WAKE;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they track r_state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= CG_WAKE;
      r_cnt          <= '0;
      r_cg_en        <= 1'b1;
      r_domain_ready <= 1'b0;
      r_gated        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_cg_en        <= (w_state_next != CG_GATED);
      r_domain_ready <= (w_state_next == CG_ACTIVE);
      r_gated        <= (w_state_next == CG_GATED);
    end
  end

  assign cg_en        = r_cg_en;
  assign domain_ready = r_domain_ready;
  assign gated        = r_gated;

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Directed bench for cg_enable_ctrl with a latch-based clock gate model downstream.
module tb_cg_enable_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic activity = 1'b0;
  logic drain_done = 1'b0;
  logic force_on = 1'b0;
  logic cg_en;
  logic domain_ready;
  logic gated;

  int n_tests = 0;
  int n_fail  = 0;

  logic en_lat;
  logic gclk;
  realtime t_rise = 0.0;
  int runt_cnt = 0;

  always #5 clk = ~clk;

  cg_enable_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .activity    (activity),
    .drain_done  (drain_done),
    .force_on    (force_on),
    .cg_en       (cg_en),
    .domain_ready(domain_ready),
    .gated       (gated)
  );

  // cgcontrol model: enable latch transparent while clk is low
  always @(clk or cg_en) if (!clk) en_lat = cg_en;
  assign gclk = clk & en_lat;

  always @(posedge gclk) t_rise = $realtime;
  always @(negedge gclk) begin
    if (t_rise > 0.0 && ($realtime - t_rise) < 4.5) runt_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; activity = 1'b0; drain_done = 1'b0; force_on = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_values got=%b exp=100", {cg_en, domain_ready, gated});
    end
    rst = 1'b0;
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_wake1 got=%b exp=100", {cg_en, domain_ready, gated});
    end
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_wake_done got=%b exp=110", {cg_en, domain_ready, gated});
    end
    $display("[TB] reset release: en=%b ready=%b gated=%b", cg_en, domain_ready, gated);
  endtask

  task automatic test_idle_entry();
    activity = 1'b0; drain_done = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++;
      if (domain_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_entry_count%0d ready got=%b exp=1", i, domain_ready);
      end
    end
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_entry_prep got=%b exp=100", {cg_en, domain_ready, gated});
    end
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b001) begin
      n_fail++;
      $display("FAIL idle_entry_gated got=%b exp=001", {cg_en, domain_ready, gated});
    end
    step();
    n_tests++;
    if (gclk !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_entry_gclk got=%b exp=0", gclk);
    end
    $display("[TB] idle entry: en=%b gated=%b gclk=%b", cg_en, gated, gclk);
  endtask

  task automatic test_wake();
    drain_done = 1'b0;
    step();
    n_tests++;
    if ({cg_en, gated} !== 2'b01) begin
      n_fail++;
      $display("FAIL wake_drain_ignored got=%b exp=01", {cg_en, gated});
    end
    activity = 1'b1;
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL wake_en got=%b exp=100", {cg_en, domain_ready, gated});
    end
    activity = 1'b0; drain_done = 1'b1;
    step();
    n_tests++;
    if (domain_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_ready_early got=%b exp=0", domain_ready);
    end
    n_tests++;
    if (gclk !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_gclk_resumed got=%b exp=1", gclk);
    end
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b110) begin
      n_fail++;
      $display("FAIL wake_ready got=%b exp=110", {cg_en, domain_ready, gated});
    end
    activity = 1'b1;
    step();
    n_tests++;
    if (runt_cnt !== 0) begin
      n_fail++;
      $display("FAIL wake_runt_pulses got=%0d exp=0", runt_cnt);
    end
    $display("[TB] wake: en=%b ready=%b runts=%0d", cg_en, domain_ready, runt_cnt);
  endtask

  task automatic test_idle_restart();
    activity = 1'b0; drain_done = 1'b1;
    repeat (3) step();
    activity = 1'b1;
    step();
    activity = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_tests++;
      if ({cg_en, domain_ready} !== 2'b11) begin
        n_fail++;
        $display("FAIL restart_count%0d got=%b exp=11", i, {cg_en, domain_ready});
      end
    end
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart_prep got=%b exp=100", {cg_en, domain_ready, gated});
    end
    step();
    n_tests++;
    if ({cg_en, gated} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_gated got=%b exp=01", {cg_en, gated});
    end
    $display("[TB] idle restart: en=%b gated=%b", cg_en, gated);
    activity = 1'b1;
    repeat (3) step();
    n_tests++;
    if (domain_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_rewake got=%b exp=1", domain_ready);
    end
  endtask

  task automatic test_prep_abort();
    logic en_dropped;
    en_dropped = 1'b0;
    for (int k = 0; k < 2; k++) begin
      activity = 1'b0; drain_done = 1'b1; force_on = 1'b0;
      repeat (4) begin
        step();
        if (cg_en !== 1'b1) en_dropped = 1'b1;
      end
      n_tests++;
      if (domain_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL prep_abort%0d_in_prep ready got=%b exp=0", k, domain_ready);
      end
      if (k == 0) activity = 1'b1;
      else force_on = 1'b1;
      step();
      if (cg_en !== 1'b1) en_dropped = 1'b1;
      n_tests++;
      if ({cg_en, domain_ready, gated} !== 3'b110) begin
        n_fail++;
        $display("FAIL prep_abort%0d got=%b exp=110", k, {cg_en, domain_ready, gated});
      end
      $display("[TB] prep abort %0d: en=%b ready=%b", k, cg_en, domain_ready);
    end
    n_tests++;
    if (en_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL prep_abort_en_dropped got=%b exp=0", en_dropped);
    end
  endtask

  task automatic test_override_and_reset();
    logic bad;
    bad = 1'b0;
    activity = 1'b0; drain_done = 1'b1; force_on = 1'b1;
    repeat (20) begin
      step();
      if ({cg_en, domain_ready} !== 2'b11) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL force_on_blocks got=%b exp=0", bad);
    end
    bad = 1'b0;
    force_on = 1'b0; drain_done = 1'b0;
    repeat (10) begin
      step();
      if ({cg_en, domain_ready} !== 2'b11) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL not_drained_blocks got=%b exp=0", bad);
    end
    drain_done = 1'b1;
    repeat (5) step();
    n_tests++;
    if (gated !== 1'b1) begin
      n_fail++;
      $display("FAIL force_pre_gated got=%b exp=1", gated);
    end
    force_on = 1'b1;
    step();
    n_tests++;
    if ({cg_en, gated} !== 2'b10) begin
      n_fail++;
      $display("FAIL force_wake got=%b exp=10", {cg_en, gated});
    end
    $display("[TB] force_on: en=%b gated=%b", cg_en, gated);
    force_on = 1'b0;
    repeat (2 + 5) step();
    n_tests++;
    if (gated !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_gated got=%b exp=1", gated);
    end
    rst = 1'b1;
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL midop_rst got=%b exp=100", {cg_en, domain_ready, gated});
    end
    rst = 1'b0;
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b100) begin
      n_fail++;
      $display("FAIL midop_rst_wake1 got=%b exp=100", {cg_en, domain_ready, gated});
    end
    step();
    n_tests++;
    if ({cg_en, domain_ready, gated} !== 3'b110) begin
      n_fail++;
      $display("FAIL midop_rst_ready got=%b exp=110", {cg_en, domain_ready, gated});
    end
    $display("[TB] mid-op reset: en=%b ready=%b gated=%b", cg_en, domain_ready, gated);
  endtask

  initial begin
    test_reset();
    test_idle_entry();
    test_wake();
    test_idle_restart();
    test_prep_abort();
    test_override_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
